// File: rtl/bus_arbiter.sv
// Purpose: round-robin arbiter sharing one slave bus among NUM_M masters via breq/bgrant, with one-hot registered grants.
// Latency: grant 1 cycle after breq is sampled; there is a one-cycle HANDOVER gap (bgrant=0) between consecutive owners.
// Backpressure: the grant is held while breq[owner] stays high; ARB_TIMEOUT_EN adds a watchdog that revokes the grant after TIMEOUT cycles without ready.
module bus_arbiter #(
  parameter  int NUM_M   = 2,
  parameter  int TIMEOUT = 64,
  localparam int OW      = (NUM_M > 2) ? $clog2(NUM_M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] breq,
  input  logic             ready,
  output logic [NUM_M-1:0] bgrant,
  output logic [OW-1:0]    owner,
  output logic             bus_busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t           state;
  logic [OW-1:0]    rr_ptr;
  logic [NUM_M-1:0] mask;
  logic [NUM_M-1:0] elig;
  logic             any_elig;
  logic [OW-1:0]    winner;
  logic             wd_fire;

  assign elig = breq & ~mask;

  // Pick the first eligible master, scanning upward from rr_ptr with wraparound.
  // The scan runs from the farthest offset down to offset 0, so the nearest candidate is the last one written and wins.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_M]) begin
        any_elig = 1'b1;
        winner   = OW'((int'(rr_ptr) + k) % NUM_M);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        grant_start;

  assign grant_start = (state != GRANT) && any_elig;
  // The watchdog fires only if the owner is still requesting; a release on the same cycle takes priority.
  assign wd_fire     = (state == GRANT) && breq[owner] && !ready && (wd_cnt == 16'(TIMEOUT));

  // Watchdog counter, per-master revoke mask, and the timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      mask        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if (grant_start || ready)
        wd_cnt <= '0;
      else if ((state == GRANT) && (wd_cnt != 16'(TIMEOUT)))
        wd_cnt <= wd_cnt + 16'd1;
      // A mask bit stays set only while the revoked master keeps breq high.
      mask <= mask & breq;
      if (wd_fire)
        mask[owner] <= 1'b1;
    end
  end
`else
  logic unused_ready;

  assign mask         = '0;
  assign wd_fire      = 1'b0;
  assign timeout_err  = 1'b0;
  assign unused_ready = ready;
`endif

  // Arbitration FSM; grant, owner and busy are all registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bgrant   <= '0;
      owner    <= '0;
      bus_busy <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE, HANDOVER: begin
          if (any_elig) begin
            state    <= GRANT;
            bgrant   <= {{(NUM_M-1){1'b0}}, 1'b1} << winner;
            owner    <= winner;
            bus_busy <= 1'b1;
            rr_ptr   <= (winner == OW'(NUM_M - 1)) ? '0 : winner + 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!breq[owner] || wd_fire) begin
            state    <= HANDOVER;
            bgrant   <= '0;
            bus_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bgrant   <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by random traffic, checked against a bus-ownership model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// ARB_TIMEOUT_EN enables the watchdog scenario and the revoke rules in the model.
module tb_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;
  localparam int OW = (N > 2) ? $clog2(N) : 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  breq;
  logic          ready;
  logic [N-1:0]  bgrant;
  logic [OW-1:0] owner;
  logic          bus_busy;
  logic          timeout_err;

  int vectors    = 0;
  int miscompares = 0;

  // Model: which master holds the bus (-1 = none), the last owner, the next
  // round-robin start, cycles held without ready, and revoked masters.
  int     holder  = -1;
  int     m_owner = 0;
  int     rr      = 0;
  int     quiet   = 0;
  bit     m_err   = 1'b0;
  bit [N-1:0] blocked = '0;

  bus_arbiter #(.NUM_M(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .breq(breq), .ready(ready),
    .bgrant(bgrant), .owner(owner), .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the ownership model by one clock, given the inputs sampled at that edge.
  task automatic mdl_step(input logic [N-1:0] req, input logic rdy, input logic rst);
    bit revoked = 1'b0;
    bit found   = 1'b0;
    int victim  = 0;
    if (!rst) begin
      holder = -1; m_owner = 0; rr = 0; quiet = 0; blocked = '0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (holder >= 0) begin
      if (!req[holder]) holder = -1;
`ifdef ARB_TIMEOUT_EN
      else if (quiet == TO && !rdy) begin
        revoked = 1'b1; victim = holder; holder = -1; m_err = 1'b1;
      end else begin
        quiet = rdy ? 0 : ((quiet < TO) ? quiet + 1 : TO);
      end
`endif
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!found && req[i] && !blocked[i]) begin
          found = 1'b1; holder = i; m_owner = i; rr = (i + 1) % N; quiet = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) blocked[i] = 1'b0;
    if (revoked) blocked[victim] = 1'b1;
  endtask

  // Drive one cycle of inputs, clock it, update the model, and compare every output.
  task automatic tick(input logic [N-1:0] r, input logic rdy, input logic rst);
    logic [N-1:0] eg;
    rst_n = rst; breq = r; ready = rdy;
    @(posedge clk);
    mdl_step(r, rdy, rst);
    #1;
    eg = '0;
    if (holder >= 0) eg[holder] = 1'b1;
    chk("bgrant",      32'(bgrant),      32'(eg));
    chk("owner",       32'(owner),       32'(m_owner));
    chk("bus_busy",    32'(bus_busy),    32'(holder >= 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  initial begin
    logic [N-1:0] r;
    int held;
    rst_n = 1'b0; breq = '0; ready = 1'b0;

    // Reset with both masters requesting; the first grant after release goes to master 0.
    repeat (3) tick(2'b11, 1'b0, 1'b0);
    tick(2'b11, 1'b1, 1'b1);
    tick(2'b10, 1'b1, 1'b1);
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b1);

    // Single request from master 1, held for 5 cycles and then dropped.
    repeat (5) tick(2'b10, 1'b0, 1'b1);
    repeat (3) tick(2'b00, 1'b0, 1'b1);

    // Contention: each grantee drops breq for one cycle after 4 granted cycles.
    held = 0;
    repeat (30) begin
      r = 2'b11;
      if (holder >= 0 && held == 4) begin r[holder] = 1'b0; held = 0; end
      tick(r, 1'b1, 1'b1);
      if (holder >= 0 && r == 2'b11) held++;
    end
    repeat (2) tick(2'b00, 1'b0, 1'b1);

    // No preemption: master 1 keeps the bus while master 0 waits.
    tick(2'b10, 1'b0, 1'b1);
    repeat (4) tick(2'b11, 1'b0, 1'b1);
    tick(2'b01, 1'b0, 1'b1);
    repeat (3) tick(2'b01, 1'b0, 1'b1);

    // Reset mid-grant: the grant drops at the reset edge; IDLE then re-grants.
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b1);
    repeat (2) tick(2'b00, 1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: master 0 stalls without ready; it is revoked, master 1 runs, and master 0 stays masked until it drops breq.
    tick(2'b01, 1'b0, 1'b1);
    repeat (14) tick(2'b11, 1'b0, 1'b1);
    repeat (2) tick(2'b01, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b1);
    repeat (3) tick(2'b01, 1'b1, 1'b1);
    repeat (2) tick(2'b00, 1'b0, 1'b1);
`endif

    // Random traffic: sticky requests, sparse ready, occasional reset.
    r = '0;
    repeat (600) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      tick(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
